fft8_frame_ctrl: RTL and testbench
==================================

Name: fft8_frame_ctrl

Overview:
- Frame sequencer in front of the 8-point FFT core.
- Accepts a serial stream of complex samples on a valid/ready handshake and assembles 8-sample frames.
- Drives the core's parallel inputs and its write/start/ready controls, then captures the 8 results and streams them out serially with backpressure.
- Owns all core timing, so upstream and downstream logic never touch write/start directly.

Parameters:
- DW, 16, sample component width (two's complement, matches core lanes).
- START_CYCLES, 2, cycles core_start is held. The core registers its butterfly stage on the first start cycle and its output stage on the next.
- TIMEOUT, 16, cycles to wait for core_ready after start before declaring a frame error.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  controller can accept a sample.
- s_real  in  DW  input real part.
- s_imag  in  DW  input imaginary part.
- s_last  in  1  marks final sample of a frame.
- m_valid  out  1  output bin valid.
- m_ready  in  1  downstream accepts bin.
- m_real  out  DW  output bin real part.
- m_imag  out  DW  output bin imaginary part.
- m_index  out  3  bin number 0..7.
- m_last  out  1  high with bin 7.
- core_write  out  1  load pulse to core.
- core_start  out  1  compute enable to core.
- core_in_real  out  8*DW  lane k at [DW*k+DW-1:DW*k].
- core_in_imag  out  8*DW  same lane layout.
- core_out_real  in  8*DW  core results, same layout.
- core_out_imag  in  8*DW  core results, same layout.
- core_ready  in  1  core result-ready flag.
- busy  out  1  high in every state except LOAD.
- frame_err  out  1  one-cycle error pulse.
- frame_count  out  16  completed frames, wraps 0xFFFF->0.

Behaviour:
- Clock and reset: one clock CLK. RST is synchronous and active-high. While RST is sampled high:
  - state=LOAD, idx=0.
  - s_ready=1; m_valid=0, m_last=0, m_index=0, m_real=0, m_imag=0.
  - core_write=0, core_start=0, busy=0, frame_err=0, frame_count=0.
  - Buffers cleared to 0.
- Reset mid-operation: RST in any state abandons the frame; the values above hold from the next edge and no partial output is emitted.
- LOAD:
  - s_ready=1. On s_valid&s_ready, store the sample in input lane idx, then idx++.
  - Frame closes on the handshake with idx==7, or on s_last with idx<7.
  - Early s_last (idx<7): lanes idx+1..7 are written 0 and frame_err pulses.
  - s_last=0 on idx==7: frame_err pulses and the frame still closes.
  - Go to WRITE.
- WRITE: s_ready=0, core_write=1 for exactly one cycle, then START.
- START:
  - core_start=1 for exactly START_CYCLES consecutive cycles, then WAIT.
  - core_write and core_start are never high in the same cycle.
- WAIT:
  - If core_ready=1: capture all core_out lanes into the output buffer in that cycle, go to UNLOAD.
  - If core_ready has not been seen within TIMEOUT cycles: pulse frame_err, return to LOAD; no output, frame_count unchanged.
- UNLOAD:
  - m_valid=1, m_index=odx, m_real/m_imag = output lane odx, m_last=(odx==7).
  - All m_* outputs stay stable while m_valid&!m_ready.
  - odx advances only on m_valid&m_ready.
  - After the handshake at odx==7: frame_count++, odx=0, go to LOAD; m_valid is low the next cycle.
  - s_ready stays 0 throughout; there is no frame overlap.
- Latency: with the last input handshake at cycle T and core_ready already valid, core_write is high at T+1, core_start at T+2..T+1+START_CYCLES, capture at T+2+START_CYCLES, and the first m_valid at T+3+START_CYCLES (T+5 by default).
- Arithmetic: no arithmetic on samples; lanes pass bit-exact both ways. frame_count wraps modulo 2^16.
- Simultaneous events: an error and frame close in the same cycle yield a single frame_err pulse. frame_err is never high for two consecutive cycles within one frame.

Decomposition:
- Package fft8_pkg holds:
  - state enum {LOAD, WRITE, START, WAIT, UNLOAD};
  - NPOINT=8; IDXW=3; DW default;
  - lane-slice helper constants.
- Sub-module fft8_sample_buf: 8-entry complex register file with indexed write, bulk parallel load, clear, and indexed read mux. Instantiated twice, once as the input buffer and once as the output buffer. The FSM and counters remain in the top.

Test Plan:
- Impulse (real core): sample0=(0x0100,0), samples1..7=0, s_last on 7 -> bins 0..7 each real 0x0100, imag 0, m_index 0..7 in order, m_last only on 7, frame_count 0->1, first m_valid 5 cycles after last input handshake.
- DC: all 8 samples real 0x0010, imag 0 -> bin0 real 0x0080, all other bins 0, no frame_err.
- Backpressure: m_ready toggles 1,0,1,0 -> m_* stable on each stalled cycle, exactly 8 handshakes, s_ready stays 0 until after bin 7.
- Early s_last on 5th sample (idx 4) -> one-cycle frame_err, core_in lanes 5..7 = 0 at core_write, 8 bins still delivered.
- Core stub with core_ready stuck 0 -> frame_err TIMEOUT(16) cycles after WAIT entry, no m_valid, s_ready=1 next cycle, frame_count unchanged.
- RST asserted while m_index=3 awaiting m_ready -> next cycle m_valid=0, s_ready=1, frame_count=0, core_start=0; a new full frame then completes normally.

Source files
------------

// File: rtl/fft8_pkg.sv
// Shared types and constants for the 8-point FFT frame sequencer.
package fft8_pkg;

    localparam int NPOINT     = 8;
    localparam int IDXW       = 3;
    localparam int DW_DEFAULT = 16;
    localparam int LAST_IDX   = NPOINT - 1;

    typedef enum logic [2:0] {
        LOAD,
        WRITE,
        START,
        WAIT,
        UNLOAD
    } state_e;

    // Lane k of a flattened lane bus occupies [w*k +: w].
    function automatic int lane_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/fft8_sample_buf.sv
// Eight-entry complex register file: indexed write, bulk parallel load,
// clear, indexed read mux and a flattened view of every lane.
module fft8_sample_buf
    import fft8_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 wr_en,
    input  logic [IDXW-1:0]      wr_idx,
    input  logic [DW-1:0]        wr_real,
    input  logic [DW-1:0]        wr_imag,
    input  logic                 ld_en,
    input  logic [NPOINT*DW-1:0] ld_real,
    input  logic [NPOINT*DW-1:0] ld_imag,
    input  logic [IDXW-1:0]      rd_idx,
    output logic [DW-1:0]        rd_real,
    output logic [DW-1:0]        rd_imag,
    output logic [NPOINT*DW-1:0] all_real,
    output logic [NPOINT*DW-1:0] all_imag
);

    logic [DW-1:0] re_q [NPOINT];
    logic [DW-1:0] im_q [NPOINT];
    logic [DW-1:0] re_d [NPOINT];
    logic [DW-1:0] im_d [NPOINT];

    // NOTE: start from the current contents so every path assigns re_d/im_d; no latch.
    always_comb begin
        re_d = re_q;
        im_d = im_q;
        if (clr) begin
            for (int k = 0; k < NPOINT; k++) begin
                re_d[k] = '0;
                im_d[k] = '0;
            end
        end else if (ld_en) begin
            for (int k = 0; k < NPOINT; k++) begin
                re_d[k] = ld_real[lane_lo(k, DW) +: DW];
                im_d[k] = ld_imag[lane_lo(k, DW) +: DW];
            end
        end else if (wr_en) begin
            re_d[wr_idx] = wr_real;
            im_d[wr_idx] = wr_imag;
        end
    end

    // NOTE: the storage is reset on purpose: lanes a short frame never writes must read as zero.
    // NOTE: state updates use <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NPOINT; k++) begin
                re_q[k] <= '0;
                im_q[k] <= '0;
            end
        end else begin
            re_q <= re_d;
            im_q <= im_d;
        end
    end

    assign rd_real = re_q[rd_idx];
    assign rd_imag = im_q[rd_idx];

    always_comb begin
        all_real = '0;
        all_imag = '0;
        for (int k = 0; k < NPOINT; k++) begin
            all_real[lane_lo(k, DW) +: DW] = re_q[k];
            all_imag[lane_lo(k, DW) +: DW] = im_q[k];
        end
    end

endmodule

// File: rtl/fft8_frame_ctrl.sv
// Frame sequencer for the 8-point FFT core: assembles input frames, drives the
// core write/start handshake, captures results and streams bins out.
module fft8_frame_ctrl
    import fft8_pkg::*;
#(
    parameter int DW           = DW_DEFAULT,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DW-1:0]        s_real,
    input  logic [DW-1:0]        s_imag,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DW-1:0]        m_real,
    output logic [DW-1:0]        m_imag,
    output logic [2:0]           m_index,
    output logic                 m_last,
    output logic                 core_write,
    output logic                 core_start,
    output logic [NPOINT*DW-1:0] core_in_real,
    output logic [NPOINT*DW-1:0] core_in_imag,
    input  logic [NPOINT*DW-1:0] core_out_real,
    input  logic [NPOINT*DW-1:0] core_out_imag,
    input  logic                 core_ready,
    output logic                 busy,
    output logic                 frame_err,
    output logic [15:0]          frame_count
);

    localparam int CNT_MAX = (TIMEOUT > START_CYCLES) ? TIMEOUT : START_CYCLES;
    localparam int CNTW    = $clog2(CNT_MAX) + 1;

    state_e          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] odx_q, odx_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [15:0]     frame_count_q, frame_count_d;
    logic            s_ready_q, s_ready_d;
    logic            m_valid_q, m_valid_d;
    logic            m_last_q, m_last_d;
    logic            core_write_q, core_write_d;
    logic            core_start_q, core_start_d;
    logic            busy_q, busy_d;
    logic            frame_err_q, frame_err_d;

    logic            ibuf_clr, ibuf_wr, obuf_ld;
    logic [DW-1:0]   ibuf_rd_real_unused, ibuf_rd_imag_unused;
    logic [NPOINT*DW-1:0] obuf_all_real_unused, obuf_all_imag_unused;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        odx_d         = odx_q;
        cnt_d         = cnt_q;
        frame_count_d = frame_count_q;
        frame_err_d   = 1'b0;
        ibuf_clr      = 1'b0;
        ibuf_wr       = 1'b0;
        obuf_ld       = 1'b0;

        case (state_q)
            LOAD: begin
                if (s_valid && s_ready_q) begin
                    ibuf_wr = 1'b1;
                    idx_d   = idx_q + IDXW'(1);
                    if (idx_q == IDXW'(LAST_IDX) || s_last) begin
                        // A frame closes cleanly only when s_last lands exactly on lane 7.
                        frame_err_d = !(idx_q == IDXW'(LAST_IDX) && s_last);
                        idx_d       = '0;
                        state_d     = WRITE;
                    end
                end
            end
            WRITE: begin
                cnt_d   = '0;
                state_d = START;
            end
            START: begin
                if (cnt_q == CNTW'(START_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            WAIT: begin
                if (core_ready) begin
                    obuf_ld = 1'b1;
                    odx_d   = '0;
                    state_d = UNLOAD;
                end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
                    frame_err_d = 1'b1;
                    ibuf_clr    = 1'b1;
                    state_d     = LOAD;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            UNLOAD: begin
                if (m_valid_q && m_ready) begin
                    if (odx_q == IDXW'(LAST_IDX)) begin
                        odx_d         = '0;
                        frame_count_d = frame_count_q + 16'd1;
                        ibuf_clr      = 1'b1;
                        state_d       = LOAD;
                    end else begin
                        odx_d = odx_q + IDXW'(1);
                    end
                end
            end
            default: state_d = LOAD;
        endcase

        // Outputs are decoded from the next state so they appear registered.
        s_ready_d    = (state_d == LOAD);
        busy_d       = (state_d != LOAD);
        core_write_d = (state_d == WRITE);
        core_start_d = (state_d == START);
        m_valid_d    = (state_d == UNLOAD);
        m_last_d     = (state_d == UNLOAD) && (odx_d == IDXW'(LAST_IDX));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= LOAD;
            idx_q         <= '0;
            odx_q         <= '0;
            cnt_q         <= '0;
            frame_count_q <= '0;
            s_ready_q     <= 1'b1;
            m_valid_q     <= 1'b0;
            m_last_q      <= 1'b0;
            core_write_q  <= 1'b0;
            core_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            odx_q         <= odx_d;
            cnt_q         <= cnt_d;
            frame_count_q <= frame_count_d;
            s_ready_q     <= s_ready_d;
            m_valid_q     <= m_valid_d;
            m_last_q      <= m_last_d;
            core_write_q  <= core_write_d;
            core_start_q  <= core_start_d;
            busy_q        <= busy_d;
            frame_err_q   <= frame_err_d;
        end
    end

    fft8_sample_buf #(.DW(DW)) u_ibuf (
        .clk      (CLK),
        .rst      (RST),
        .clr      (ibuf_clr),
        .wr_en    (ibuf_wr),
        .wr_idx   (idx_q),
        .wr_real  (s_real),
        .wr_imag  (s_imag),
        .ld_en    (1'b0),
        .ld_real  ({NPOINT*DW{1'b0}}),
        .ld_imag  ({NPOINT*DW{1'b0}}),
        .rd_idx   ({IDXW{1'b0}}),
        .rd_real  (ibuf_rd_real_unused),
        .rd_imag  (ibuf_rd_imag_unused),
        .all_real (core_in_real),
        .all_imag (core_in_imag)
    );

    fft8_sample_buf #(.DW(DW)) u_obuf (
        .clk      (CLK),
        .rst      (RST),
        .clr      (1'b0),
        .wr_en    (1'b0),
        .wr_idx   ({IDXW{1'b0}}),
        .wr_real  ({DW{1'b0}}),
        .wr_imag  ({DW{1'b0}}),
        .ld_en    (obuf_ld),
        .ld_real  (core_out_real),
        .ld_imag  (core_out_imag),
        .rd_idx   (odx_q),
        .rd_real  (m_real),
        .rd_imag  (m_imag),
        .all_real (obuf_all_real_unused),
        .all_imag (obuf_all_imag_unused)
    );

    assign s_ready     = s_ready_q;
    assign m_valid     = m_valid_q;
    assign m_last      = m_last_q;
    assign m_index     = odx_q;
    assign core_write  = core_write_q;
    assign core_start  = core_start_q;
    assign busy        = busy_q;
    assign frame_err   = frame_err_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// Directed bench for fft8_frame_ctrl with a stub core that only publishes its
// results after both start cycles.
module tb_fft8_frame_ctrl;

    logic         CLK = 1'b0;
    logic         RST;
    logic         s_valid, s_ready, s_last;
    logic [15:0]  s_real, s_imag;
    logic         m_valid, m_ready, m_last;
    logic [15:0]  m_real, m_imag;
    logic [2:0]   m_index;
    logic         core_write, core_start, core_ready;
    logic [127:0] core_in_real, core_in_imag;
    logic [127:0] core_out_real, core_out_imag;
    logic         busy, frame_err;
    logic [15:0]  frame_count;

    always #5 CLK = ~CLK;

    fft8_frame_ctrl dut (
        .CLK           (CLK),
        .RST           (RST),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_real        (s_real),
        .s_imag        (s_imag),
        .s_last        (s_last),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_real        (m_real),
        .m_imag        (m_imag),
        .m_index       (m_index),
        .m_last        (m_last),
        .core_write    (core_write),
        .core_start    (core_start),
        .core_in_real  (core_in_real),
        .core_in_imag  (core_in_imag),
        .core_out_real (core_out_real),
        .core_out_imag (core_out_imag),
        .core_ready    (core_ready),
        .busy          (busy),
        .frame_err     (frame_err),
        .frame_count   (frame_count)
    );

    // Stub core: results are garbage until the second start cycle has been seen.
    logic [7:0][15:0] stub_bin_re, stub_bin_im;
    int               start_seen;

    always @(posedge CLK) begin
        if (RST) begin
            core_out_real <= '0;
            core_out_imag <= '0;
            start_seen    <= 0;
        end else if (core_write) begin
            core_out_real <= {8{16'hDEAD}};
            core_out_imag <= {8{16'hBEEF}};
            start_seen    <= 0;
        end else if (core_start) begin
            start_seen <= start_seen + 1;
            if (start_seen == 1) begin
                core_out_real <= stub_bin_re;
                core_out_imag <= stub_bin_im;
            end
        end
    end

    typedef struct packed {
        logic [7:0][15:0] in_re;
        logic [7:0][15:0] in_im;
        logic [7:0][15:0] lane_re;
        logic [7:0][15:0] lane_im;
        logic [7:0][15:0] bin_re;
        logic [7:0][15:0] bin_im;
        logic [3:0]       nsamp;
        logic             last_flag;
        logic             exp_err;
        logic             bp;
    } frame_vec_t;

    frame_vec_t vecs [5];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         exp_fc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, want);
    endtask

    // mode 0: normal frame, mode 1: core_ready stuck low, mode 2: stall on bin 3 and stop
    task automatic run_frame(input int v, input int mode);
        frame_vec_t       fv;
        int               t_write, first_start, n_start, t_mvalid, n_err, t_err, n, stall3;
        logic             done, stalled, end_next;
        logic [15:0]      prev_re, prev_im;
        logic [2:0]       prev_idx;
        fv          = vecs[v];
        stub_bin_re = fv.bin_re;
        stub_bin_im = fv.bin_im;
        core_ready  = (mode != 1);
        t_write = 0; first_start = 0; n_start = 0; t_mvalid = 0;
        n_err = 0; t_err = 0; n = 0; stall3 = 0;
        done = 1'b0; stalled = 1'b0; end_next = 1'b0;
        prev_re = '0; prev_im = '0; prev_idx = '0;

        @(posedge CLK); #1;
        for (int i = 0; i < int'(fv.nsamp); i++) begin
            s_valid = 1'b1;
            s_real  = fv.in_re[i];
            s_imag  = fv.in_im[i];
            s_last  = fv.last_flag && (i == int'(fv.nsamp) - 1);
            @(negedge CLK);
            check("s_ready_load", 32'(s_ready), 32'd1);
            @(posedge CLK); #1;
        end
        s_valid = 1'b0; s_last = 1'b0; s_real = '0; s_imag = '0;

        // k counts cycles after the closing input handshake.
        for (int k = 1; k <= 60 && !done; k++) begin
            if (k > 1) begin @(posedge CLK); #1; end
            if (mode == 2)  m_ready = (n < 3);
            else if (fv.bp) m_ready = (k % 2 == 1);
            else            m_ready = 1'b1;
            @(negedge CLK);
            if (core_write || core_start)
                check("wr_start_excl", 32'(core_write & core_start), 32'd0);
            if (busy) check("s_ready_busy", 32'(s_ready), 32'd0);
            if (core_write && t_write == 0) begin
                t_write = k;
                for (int j = 0; j < 8; j++) begin
                    check($sformatf("lane_re%0d", j), 32'(core_in_real[16*j +: 16]), 32'(fv.lane_re[j]));
                    check($sformatf("lane_im%0d", j), 32'(core_in_imag[16*j +: 16]), 32'(fv.lane_im[j]));
                end
            end
            if (core_start) begin
                n_start++;
                if (first_start == 0) first_start = k;
            end
            if (frame_err) begin
                n_err++;
                t_err = k;
                if (mode == 1) begin
                    check("to_s_ready", 32'(s_ready), 32'd1);
                    check("to_frame_count", 32'(frame_count), 32'(exp_fc));
                    done = 1'b1;
                end
            end
            if (end_next) begin
                check("end_m_valid", 32'(m_valid), 32'd0);
                check("end_s_ready", 32'(s_ready), 32'd1);
                check("end_busy", 32'(busy), 32'd0);
                check("end_frame_count", 32'(frame_count), 32'(exp_fc));
                done = 1'b1;
            end else if (m_valid) begin
                if (t_mvalid == 0) t_mvalid = k;
                if (stalled) begin
                    check("stall_index", 32'(m_index), 32'(prev_idx));
                    check("stall_real", 32'(m_real), 32'(prev_re));
                    check("stall_imag", 32'(m_imag), 32'(prev_im));
                end
                check("m_index", 32'(m_index), 32'(n));
                check("m_real", 32'(m_real), 32'(fv.bin_re[n]));
                check("m_imag", 32'(m_imag), 32'(fv.bin_im[n]));
                check("m_last", 32'(m_last), 32'(n == 7));
                prev_idx = m_index; prev_re = m_real; prev_im = m_imag;
                stalled  = !m_ready;
                if (mode == 2 && n == 3 && !m_ready) begin
                    stall3++;
                    if (stall3 == 2) done = 1'b1;
                end
                if (m_ready) begin
                    n++;
                    if (n == 8) begin
                        exp_fc++;
                        end_next = 1'b1;
                    end
                end
            end
        end

        if (!done) check("frame_done", 32'd0, 32'd1);
        check("t_core_write", 32'(t_write), 32'd1);
        check("t_first_start", 32'(first_start), 32'd2);
        check("n_start", 32'(n_start), 32'd2);
        if (mode == 1) begin
            check("t_timeout_err", 32'(t_err), 32'd20);
            check("n_err", 32'(n_err), 32'd1);
            check("t_m_valid_none", 32'(t_mvalid), 32'd0);
        end else begin
            check("t_m_valid", 32'(t_mvalid), 32'd5);
            check("n_err", 32'(n_err), 32'(fv.exp_err));
            if (fv.exp_err) check("t_err", 32'(t_err), 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 5; i++) vecs[i] = '0;
        // 0: impulse
        vecs[0].in_re[0] = 16'h0100;
        for (int k = 0; k < 8; k++) vecs[0].bin_re[k] = 16'h0100;
        vecs[0].nsamp = 4'd8; vecs[0].last_flag = 1'b1;
        // 1: DC
        for (int k = 0; k < 8; k++) vecs[1].in_re[k] = 16'h0010;
        vecs[1].bin_re[0] = 16'h0080;
        vecs[1].nsamp = 4'd8; vecs[1].last_flag = 1'b1;
        // 2: early s_last on idx 4
        for (int k = 0; k < 8; k++) begin
            vecs[2].in_re[k]  = (k < 5) ? 16'(16'h0011 * (k + 1)) : 16'h7777;
            vecs[2].in_im[k]  = 16'(16'hFF00 + k);
            vecs[2].bin_re[k] = 16'(16'hA000 + k);
            vecs[2].bin_im[k] = 16'(16'h5A00 + k);
        end
        vecs[2].nsamp = 4'd5; vecs[2].last_flag = 1'b1; vecs[2].exp_err = 1'b1;
        // 3: backpressure
        for (int k = 0; k < 8; k++) begin
            vecs[3].in_re[k]  = 16'(16'h1000 + 16'h0101 * k);
            vecs[3].in_im[k]  = 16'(16'h8000 + k);
            vecs[3].bin_re[k] = 16'hF0F0 ^ 16'(k);
            vecs[3].bin_im[k] = 16'(16'h0123 + k);
        end
        vecs[3].nsamp = 4'd8; vecs[3].last_flag = 1'b1; vecs[3].bp = 1'b1;
        // 4: missing s_last on idx 7
        for (int k = 0; k < 8; k++) begin
            vecs[4].in_re[k]  = 16'(16'h2000 + k);
            vecs[4].bin_re[k] = 16'(16'h3000 + k);
            vecs[4].bin_im[k] = 16'(16'h4000 + k);
        end
        vecs[4].nsamp = 4'd8; vecs[4].last_flag = 1'b0; vecs[4].exp_err = 1'b1;
        // Expected core lanes: sent samples, zero beyond a short frame.
        for (int i = 0; i < 5; i++)
            for (int k = 0; k < 8; k++) begin
                vecs[i].lane_re[k] = (k < int'(vecs[i].nsamp)) ? vecs[i].in_re[k] : 16'h0000;
                vecs[i].lane_im[k] = (k < int'(vecs[i].nsamp)) ? vecs[i].in_im[k] : 16'h0000;
            end

        RST = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_real = '0; s_imag = '0;
        m_ready = 1'b0; core_ready = 1'b1;
        stub_bin_re = '0; stub_bin_im = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_index", 32'(m_index), 32'd0);
        check("rst_m_real", 32'(m_real), 32'd0);
        check("rst_m_imag", 32'(m_imag), 32'd0);
        check("rst_core_write", 32'(core_write), 32'd0);
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;

        for (int v = 0; v < 5; v++) run_frame(v, 0);
        run_frame(0, 1);

        // Reset while bin 3 is stalled, then a clean frame must follow.
        run_frame(3, 2);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        exp_fc = 0;
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        check("mid_rst_s_ready", 32'(s_ready), 32'd1);
        check("mid_rst_frame_count", 32'(frame_count), 32'd0);
        check("mid_rst_core_start", 32'(core_start), 32'd0);
        check("mid_rst_m_index", 32'(m_index), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        run_frame(0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
